// File: rtl/datawidthconv_512_to_32.sv
// Buffers a packet of 512-bit beats, then replays it as 32-bit word writes, most significant word first.
// Define DATAWIDTHCONV_512_TO_32_ERR_EN to build the sticky protocol-error flag; otherwise err is tied to 0.
module datawidthconv_512_to_32 #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_BEATS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snk_valid,
  input  logic         snk_sop,
  input  logic         snk_eop,
  input  logic [511:0] snk_d,
  output logic         snk_ready,
  output logic [31:0]  data_addr,
  output logic         data_we,
  output logic [31:0]  data_d,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int         IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [5:0] MAX_C = 6'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [3:0]         rd_word_q, rd_word_d;
  logic [IDX_W-1:0]   rd_beat_q, rd_beat_d;
  logic               issue_done_q, issue_done_d;
  logic               accept, wr_en, issue, issue_last;
  logic [IDX_W-1:0]   wr_idx;

  logic               vld_p1_q, last_p1_q;
  logic [3:0]         word_p1_q;
  logic [31:0]        rd_p1_q [16];
  logic               vld_p2_q, last_p2_q;
  logic [31:0]        data_d_q, data_addr_q, addr_next_q;

  logic [31:0]        bank_mem [16][MAX_BEATS];

  assign snk_ready = (state_q == IDLE) || (state_q == RECV);
  assign accept    = snk_valid && snk_ready;
  assign busy      = (state_q == RECV) || (state_q == SEND);
  assign done      = (state_q == DONE);
  assign data_we   = vld_p2_q;
  assign data_d    = data_d_q;
  assign data_addr = data_addr_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_word_d    = rd_word_q;
    rd_beat_d    = rd_beat_q;
    issue_done_d = issue_done_q;
    wr_en        = 1'b0;
    wr_idx       = '0;
    issue        = 1'b0;
    issue_last   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_word_d    = '0;
        rd_beat_d    = '0;
        issue_done_d = 1'b0;
        if (accept && snk_sop) begin
          wr_en   = 1'b1;
          cnt_d   = 6'd1;
          state_d = snk_eop ? SEND : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          // sop restarts at index 0; beats past capacity are dropped but eop still closes
          if (snk_sop) begin
            wr_en = 1'b1;
            cnt_d = 6'd1;
          end else if (cnt_q < MAX_C) begin
            wr_en  = 1'b1;
            wr_idx = cnt_q[IDX_W-1:0];
            cnt_d  = cnt_q + 6'd1;
          end
          if (snk_eop) state_d = SEND;
        end
      end
      SEND: begin
        issue      = !issue_done_q;
        issue_last = issue && (rd_word_q == 4'hF) && (6'(rd_beat_q) == cnt_q - 6'd1);
        if (issue) begin
          rd_word_d = rd_word_q + 4'd1;
          if (rd_word_q == 4'hF) rd_beat_d = rd_beat_q + IDX_W'(1);
        end
        if (issue_last) issue_done_d = 1'b1;
        // stay in SEND until the final word has left the output register
        if (vld_p2_q && last_p2_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_word_q    <= '0;
      rd_beat_q    <= '0;
      issue_done_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      vld_p2_q     <= 1'b0;
      last_p2_q    <= 1'b0;
      addr_next_q  <= BASE_ADDR;
      data_addr_q  <= BASE_ADDR;
      data_d_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_word_q    <= rd_word_d;
      rd_beat_q    <= rd_beat_d;
      issue_done_q <= issue_done_d;
      // stage p1: bank read registered
      vld_p1_q     <= issue;
      last_p1_q    <= issue_last;
      // stage p2: word select and write strobe
      vld_p2_q     <= vld_p1_q;
      last_p2_q    <= vld_p1_q && last_p1_q;
      if (vld_p1_q) begin
        data_d_q    <= rd_p1_q[word_p1_q];
        data_addr_q <= addr_next_q;
        addr_next_q <= addr_next_q + 32'd1;
      end else if (state_q == DONE) begin
        addr_next_q <= BASE_ADDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    word_p1_q <= rd_word_q;
    for (int b = 0; b < 16; b++) begin
      if (wr_en) bank_mem[b][wr_idx] <= snk_d[511-32*b -: 32];
      if (issue) rd_p1_q[b] <= bank_mem[b][rd_beat_q];
    end
  end

`ifdef DATAWIDTHCONV_512_TO_32_ERR_EN
  logic err_q, err_set;

  always_comb begin
    err_set = 1'b0;
    if (state_q == IDLE && snk_valid && !snk_sop) err_set = 1'b1;
    if (state_q == RECV && accept && (snk_sop || cnt_q >= MAX_C)) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_datawidthconv_512_to_32.sv
// Directed and randomized bench for datawidthconv_512_to_32 with a queue-based packet model.
module tb_datawidthconv_512_to_32;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;
  localparam int          MAXB   = 32;
`ifdef DATAWIDTHCONV_512_TO_32_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic [511:0] snk_d = '0;
  logic         rdy_a, we_a, busy_a, done_a, err_a;
  logic         rdy_b, we_b, busy_b, done_b, err_b;
  logic [31:0]  addr_a, d_a, addr_b, d_b;

  datawidthconv_512_to_32 #(.BASE_ADDR(BASE_A), .MAX_BEATS(MAXB)) dut_a (
    .clk(clk), .reset(reset), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_d(snk_d), .snk_ready(rdy_a), .data_addr(addr_a), .data_we(we_a), .data_d(d_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  datawidthconv_512_to_32 #(.BASE_ADDR(BASE_B), .MAX_BEATS(MAXB)) dut_b (
    .clk(clk), .reset(reset), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_d(snk_d), .snk_ready(rdy_b), .data_addr(addr_b), .data_we(we_b), .data_d(d_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  initial forever #5 clk = ~clk;

  typedef struct {
    int          which;
    logic [31:0] addr;
    logic [31:0] data;
    int          stamp;
  } wr_t;

  wr_t obs[$];
  int  neg_cnt = 0;
  int  rdy_viol = 0;
  int  n_pass = 0, n_chk = 0, n_fail = 0;
  int  acc_stamp = 0;
  logic [31:0] first_d0, last_d0;

  // reference model state: packet under assembly, closed packet, sticky error
  logic [511:0] mdl_buf[$];
  logic [511:0] exp_pkt[$];
  bit           mdl_in = 1'b0;
  bit           mdl_err = 1'b0;

  always @(negedge clk) begin
    if (we_a) obs.push_back('{0, addr_a, d_a, neg_cnt});
    if (we_b) obs.push_back('{1, addr_b, d_b, neg_cnt});
    if ((we_a && rdy_a) || (we_b && rdy_b) || (we_a && !busy_a)) rdy_viol++;
    neg_cnt <= neg_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_chk++;
    assert (obs_v === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs_v, exp_v);
    end
  endtask

  task automatic mdl_beat(input bit sop, input bit eop, input logic [511:0] d);
    if (!mdl_in) begin
      if (!sop) mdl_err = 1'b1;
      else begin
        mdl_buf = {d};
        if (eop) exp_pkt = mdl_buf;
        else     mdl_in = 1'b1;
      end
    end else begin
      if (sop) begin
        mdl_err = 1'b1;
        mdl_buf = {d};
      end else if (mdl_buf.size() < MAXB) mdl_buf.push_back(d);
      else mdl_err = 1'b1;
      if (eop) begin
        exp_pkt = mdl_buf;
        mdl_in  = 1'b0;
      end
    end
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [511:0] d);
    snk_valid = 1'b1; snk_sop = sop; snk_eop = eop; snk_d = d;
    @(negedge clk);
    mdl_beat(sop, eop, d);
    if (eop) acc_stamp = neg_cnt;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] pat(input int i);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = {i[15:0], k[15:0]};
    return r;
  endfunction

  task automatic check_pkt(input string tag);
    for (int w = 0; w < 2; w++) begin
      int n, bad, contig, first_st, prev_st;
      logic [31:0] base, ea, ed;
      logic [511:0] bt;
      n = 0; bad = 0; contig = 0; first_st = -100; prev_st = 0;
      base = (w == 0) ? BASE_A : BASE_B;
      foreach (obs[i]) begin
        if (obs[i].which == w) begin
          ea = base + 32'(n);
          if (n / 16 < exp_pkt.size()) begin
            bt = exp_pkt[n / 16];
            ed = bt[511-32*(n % 16) -: 32];
            if (obs[i].addr !== ea || obs[i].data !== ed) bad++;
          end else bad++;
          if (n == 0) first_st = obs[i].stamp;
          else if (obs[i].stamp != prev_st + 1) contig++;
          if (w == 0) begin
            if (n == 0) first_d0 = obs[i].data;
            last_d0 = obs[i].data;
          end
          prev_st = obs[i].stamp;
          n++;
        end
      end
      chk($sformatf("%s d%0d count", tag, w), 32'(n), 32'(16 * exp_pkt.size()));
      chk($sformatf("%s d%0d words", tag, w), 32'(bad), 32'd0);
      chk($sformatf("%s d%0d back2back", tag, w), 32'(contig), 32'd0);
      chk($sformatf("%s d%0d latency", tag, w), 32'(first_st), 32'(acc_stamp + 2));
    end
    chk({tag, " ready/busy in SEND"}, 32'(rdy_viol), 32'd0);
    chk({tag, " err_a"}, 32'(err_a), 32'(ERR_ON & mdl_err));
    chk({tag, " err_b"}, 32'(err_b), 32'(ERR_ON & mdl_err));
    obs.delete();
  endtask

  task automatic finish_pkt(input string tag);
    int k, last_st;
    k = 0;
    while (done_a !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " done_a"}, 32'(done_a), 32'd1);
    chk({tag, " done_b"}, 32'(done_b), 32'd1);
    chk({tag, " busy at done"}, 32'(busy_a), 32'd0);
    last_st = -100;
    foreach (obs[i]) if (obs[i].which == 0) last_st = obs[i].stamp;
    chk({tag, " done after last"}, 32'(neg_cnt), 32'(last_st + 1));
    @(negedge clk);
    chk({tag, " done pulse width"}, 32'(done_a), 32'd0);
    chk({tag, " ready after done"}, 32'(rdy_a), 32'd1);
    check_pkt(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_in = 1'b0;
    mdl_err = 1'b0;
    @(negedge clk);
    obs.delete();
  endtask

  initial begin
    int n, k, len;
    repeat (3) @(negedge clk);
    chk("rst ready_a", 32'(rdy_a), 32'd1);
    chk("rst we_a", 32'(we_a), 32'd0);
    chk("rst addr_a", addr_a, BASE_A);
    chk("rst addr_b", addr_b, BASE_B);
    chk("rst data_a", d_a, 32'd0);
    chk("rst busy_a", 32'(busy_a), 32'd0);
    chk("rst done_a", 32'(done_a), 32'd0);
    chk("rst err_a", 32'(err_a), 32'd0);
    chk("rst we_b", 32'(we_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // full 32-beat patterned packet
    for (int i = 0; i < 32; i++) beat(i == 0, i == 31, pat(i));
    finish_pkt("p32");
    chk("p32 first word", first_d0, 32'h0000_0000);
    chk("p32 last word", last_d0, 32'h001F_000F);

    // single beat with sop and eop together
    beat(1'b1, 1'b1, rnd512());
    finish_pkt("single");

    // 40 beats: overflow beyond capacity
    for (int i = 0; i < 40; i++) beat(i == 0, i == 39, rnd512());
    finish_pkt("ovf40");
    do_reset();

    // stray beat in IDLE, then a restart mid-packet
    beat(1'b0, 1'b0, rnd512());
    beat(1'b1, 1'b0, rnd512());
    beat(1'b0, 1'b0, rnd512());
    beat(1'b1, 1'b0, rnd512());
    beat(1'b0, 1'b0, rnd512());
    beat(1'b0, 1'b1, rnd512());
    finish_pkt("restart");
    do_reset();

    // reset at write 100 of SEND
    for (int i = 0; i < 8; i++) beat(i == 0, i == 7, rnd512());
    n = 0; k = 0;
    while (n < 100 && k < 2000) begin
      @(negedge clk);
      k++;
      if (we_a) n++;
    end
    chk("midsend reached write 100", 32'(n), 32'd100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_in = 1'b0;
    mdl_err = 1'b0;
    chk("midsend we_a", 32'(we_a), 32'd0);
    chk("midsend addr_a", addr_a, BASE_A);
    chk("midsend addr_b", addr_b, BASE_B);
    chk("midsend busy_a", 32'(busy_a), 32'd0);
    chk("midsend ready_a", 32'(rdy_a), 32'd1);
    @(negedge clk);
    chk("midsend quiet", 32'(we_a), 32'd0);
    obs.delete();
    beat(1'b1, 1'b0, rnd512());
    beat(1'b0, 1'b1, rnd512());
    finish_pkt("postrst");

    // randomized packets with idle gaps
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(1, 36);
      for (int b = 0; b < len; b++) begin
        beat(b == 0, b == len - 1, rnd512());
        if (b != len - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
      end
      finish_pkt($sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datawidthconv_512_to_32.md
DATAWIDTHCONV_512_TO_32 -- requirements
Module: datawidthconv_512_to_32

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, giving the first 32-bit word address written to the data port.
REQ-002 SHALL have parameter MAX_BEATS, default 32, giving the packet capacity in 512-bit beats; the legal range is 1..32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port snk_valid, input, 1 bit: a beat is present.
REQ-006 SHALL have port snk_sop, input, 1 bit: first beat of the packet.
REQ-007 SHALL have port snk_eop, input, 1 bit: last beat of the packet.
REQ-008 SHALL have port snk_d, input, 512 bits: beat data.
REQ-009 SHALL have port snk_ready, output, 1 bit: the block accepts beats.
REQ-010 SHALL have port data_addr, output, 32 bits: word write address.
REQ-011 SHALL have port data_we, output, 1 bit: word write strobe.
REQ-012 SHALL have port data_d, output, 32 bits: word write data.
REQ-013 SHALL have port busy, output, 1 bit: the block is in RECV or SEND.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is written.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol-error flag (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, RECV, SEND, DONE.
REQ-017 Beat acceptance SHALL occur only when snk_valid and snk_ready are both high; snk_ready SHALL be 1 in IDLE and RECV, and 0 in SEND and DONE.
REQ-018 In IDLE, an accepted beat with snk_sop=1 SHALL be stored at buffer index 0; the FSM SHALL go to RECV, or directly to SEND if snk_eop=1 on the same beat.
REQ-019 In IDLE, an accepted beat with snk_sop=0 SHALL be discarded.
REQ-020 In RECV, each accepted beat SHALL be stored at the next index; the beat with snk_eop=1 SHALL move the FSM to SEND; a beat with snk_sop=1 SHALL restart the packet at index 0.
REQ-021 Beats beyond MAX_BEATS without eop SHALL be discarded, and the packet SHALL be closed at the first subsequent eop.
REQ-022 The buffer SHALL be MAX_BEATS x 512 bits, built as 16 banks of 32 bits, with a 1-cycle registered read.
REQ-023 SEND SHALL emit 16*N words, where N is the number of stored beats; word k of a beat SHALL be snk_d[511-32k -: 32], so the most significant word goes first.
REQ-024 data_addr SHALL equal BASE_ADDR + word index, incrementing by 1 per write and wrapping modulo 2^32.
REQ-025 data_we SHALL be high for exactly 16*N consecutive cycles, with the first write 2 cycles after the clock edge that accepted the eop beat.
REQ-026 After the last write, the FSM SHALL enter DONE for 1 cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in RECV and SEND, and 0 in IDLE and DONE.
REQ-028 A new packet SHALL be accepted no earlier than the cycle after done.

Reset
REQ-029 On reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-RECV and mid-SEND, and any partial packet SHALL be dropped.
REQ-030 The reset values SHALL be: snk_ready=1, data_we=0, data_addr=BASE_ADDR, data_d=0, busy=0, done=0, err=0.
REQ-031 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro DATAWIDTHCONV_512_TO_32_ERR_EN SHALL select error reporting.
REQ-033 With the macro defined, err SHALL set and hold until reset on any of: snk_sop=1 accepted in RECV, snk_valid without snk_sop in IDLE, or beat overflow beyond MAX_BEATS.
REQ-034 Without the macro, err SHALL be tied to 0 and no error logic SHALL be built; data behaviour SHALL be identical in both builds.

Verification
REQ-035 Send 32 beats (sop on beat 0, eop on beat 31), beat i word k = {i[15:0], k[15:0]}: expect 512 writes, addr 0..511, first data_d=0x00000000, last data_d=0x001F000F, then done pulse, busy=0.
REQ-036 Send a single beat with sop=eop=1 and BASE_ADDR=0x100: expect 16 writes at addr 0x100..0x10F starting exactly 2 cycles after acceptance, snk_ready=0 throughout.
REQ-037 Send 40 beats with eop on beat 39: expect 512 writes of beats 0..31 only; with ERR_EN, err=1; without it, err=0.
REQ-038 Assert reset at write 100 of SEND: expect data_we=0 on the next cycle, addr=BASE_ADDR; a new 2-beat packet then produces 32 correct writes.
REQ-039 Send a valid beat without sop in IDLE, then a mid-RECV sop restart with 3 beats: expect the stray beat dropped and 48 writes from the restarted packet; with ERR_EN, err=1.
